// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB encodings, slave FSM state and response codes shared by ahb_param_slave
package ahb_pkg;
   typedef enum logic [1:0] {TR_IDLE, TR_BUSY, TR_NONSEQ, TR_SEQ} htrans_t;
   typedef enum logic [2:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD} hsize_t;
   typedef enum logic [2:0] {BR_SINGLE, BR_INCR, BR_WRAP4, BR_INCR4, BR_WRAP8, BR_INCR8, BR_WRAP16, BR_INCR16} hburst_t;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
   localparam logic RESP_OKAY = 1'b0;
   localparam logic RESP_ERROR = 1'b1;
endpackage

// File: rtl/ahb_param_slave_if.sv
// ahb_param_slave_if: AHB-Lite bus bundle between a master and ahb_param_slave
interface ahb_param_slave_if #(parameter int DATA_W = 32, parameter int ADDR_W = 32);
   logic hsel;
   logic [ADDR_W-1:0] haddr;
   logic hwrite;
   logic [2:0] hsize;
   logic [2:0] hburst;
   logic [3:0] hprot;
   logic [1:0] htrans;
   logic [DATA_W-1:0] hwdata;
   logic [DATA_W-1:0] hrdata;
   logic hready;
   logic hresp;
   logic error;
   modport master(output hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hwdata, input hrdata, hready, hresp, error);
   modport slave(input hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hwdata, output hrdata, hready, hresp, error);
endinterface

// File: rtl/ahb_slv_mem.sv
// ahb_slv_mem: DEPTH x DATA_W byte-enabled synchronous RAM with registered read port
module ahb_slv_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH = 256,
   localparam int AW = $clog2(DEPTH),
   localparam int NB = DATA_W / 8
) (
   input logic hclk,
   input logic hresetn,
   input logic we,
   input logic re,
   input logic [AW-1:0] waddr,
   input logic [AW-1:0] raddr,
   input logic [NB-1:0] be,
   input logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge hclk)
      for (int i = 0; i < NB; i++) if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
   // a write landing on the word being read in the same cycle is forwarded so the read is never stale
   always_ff @(posedge hclk or negedge hresetn)
      if (!hresetn) rdata <= '0;
      else if (re)
         for (int i = 0; i < NB; i++)
            rdata[8*i +: 8] <= (we && be[i] && waddr == raddr) ? wdata[8*i +: 8] : mem[raddr][8*i +: 8];
endmodule

// File: rtl/ahb_param_slave.sv
// ahb_param_slave: AHB-Lite memory slave with programmable wait states and two-cycle ERROR responses.
// Define AHB_SLV_PROT_EN to reject user-mode writes to the upper half of memory.
module ahb_param_slave import ahb_pkg::*; #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH = 256,
   parameter int WAIT_STATES = 0
) (
   input logic hclk,
   input logic hresetn,
   ahb_param_slave_if.slave bus
);
   localparam int NB = DATA_W / 8;
   localparam int BL = $clog2(NB);
   localparam int AW = $clog2(DEPTH);
   localparam int WW = ADDR_W - BL;
   state_t state;
   logic [2:0] cnt;
   logic ready, resp, err_q, pend, pw;
   logic [AW-1:0] pidx;
   logic [NB-1:0] pbe, be;
   logic [WW-1:0] word;
   logic acc, bad, prot_bad, ok, ea, we, re, unused;
   assign word = bus.haddr[ADDR_W-1:BL];
   assign acc = bus.hsel && (htrans_t'(bus.htrans) inside {TR_NONSEQ, TR_SEQ}) && ready;
`ifdef AHB_SLV_PROT_EN
   assign prot_bad = bus.hwrite && !bus.hprot[1] && word >= WW'(DEPTH / 2);
`else
   assign prot_bad = 1'b0;
`endif
   assign bad = (bus.haddr[2:0] & ~(3'b111 << bus.hsize)) != 3'b0 || bus.hsize > 3'(BL) || word >= WW'(DEPTH) || prot_bad;
   assign ok = acc && !bad;
   assign ea = acc && bad;
   assign we = pend && pw && ready;
   assign re = ok && !bus.hwrite;
   assign unused = &{1'b0, bus.hburst, bus.hprot};
   always_comb
      for (int i = 0; i < NB; i++) be[i] = (i >> bus.hsize) == (int'(bus.haddr[BL-1:0]) >> bus.hsize);
   // pend marks an accepted OKAY data phase; its write lands only on the cycle hready returns high
   always_ff @(posedge hclk or negedge hresetn)
      if (!hresetn) begin
         state <= ST_IDLE;
         cnt <= '0;
         ready <= 1'b1;
         resp <= RESP_OKAY;
         err_q <= 1'b0;
         pend <= 1'b0;
         pw <= 1'b0;
         pidx <= '0;
         pbe <= '0;
      end else begin
         err_q <= state == ST_ERR1;
         if (state == ST_WAIT) begin
            cnt <= cnt - 3'd1;
            ready <= cnt == 3'd1;
            state <= cnt == 3'd1 ? ST_IDLE : ST_WAIT;
         end else if (state == ST_ERR1) begin
            state <= ST_ERR2;
            ready <= 1'b1;
         end else begin
            pend <= ok;
            pw <= bus.hwrite;
            pidx <= bus.haddr[BL +: AW];
            pbe <= be;
            cnt <= 3'(WAIT_STATES);
            state <= ea ? ST_ERR1 : (ok && WAIT_STATES > 0) ? ST_WAIT : ST_IDLE;
            ready <= !(acc && (bad || WAIT_STATES > 0));
            resp <= ea ? RESP_ERROR : RESP_OKAY;
         end
      end
   ahb_slv_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
      .hclk(hclk),
      .hresetn(hresetn),
      .we(we),
      .re(re),
      .waddr(pidx),
      .raddr(bus.haddr[BL +: AW]),
      .be(pbe),
      .wdata(bus.hwdata),
      .rdata(bus.hrdata)
   );
   assign bus.hready = ready;
   assign bus.hresp = resp;
   assign bus.error = err_q;
endmodule

// File: tb/tb_ahb_param_slave.sv
// tb_ahb_param_slave: directed bench for a zero-wait and a three-wait slave against a byte-level memory model.
// Define AHB_SLV_PROT_EN to exercise the user-write protection of the upper half.
module tb_ahb_param_slave;
   localparam int DEPTH = 16;
`ifdef AHB_SLV_PROT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;
   ahb_param_slave_if #(.DATA_W(32), .ADDR_W(32)) b0 (), b3 ();
   ahb_param_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (.hclk(clk), .hresetn(rstn), .bus(b0));
   ahb_param_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (.hclk(clk), .hresetn(rstn), .bus(b3));
   logic which = 1'b0;
   logic hsel = 1'b0, hwrite = 1'b0;
   logic [31:0] haddr = '0, hwdata = '0;
   logic [2:0] hsize = '0, hburst = '0;
   logic [3:0] hprot = 4'h3;
   logic [1:0] htrans = '0;
   assign b0.hsel = hsel && !which;
   assign b3.hsel = hsel && which;
   assign b0.haddr = haddr;
   assign b3.haddr = haddr;
   assign b0.hwrite = hwrite;
   assign b3.hwrite = hwrite;
   assign b0.hsize = hsize;
   assign b3.hsize = hsize;
   assign b0.hburst = hburst;
   assign b3.hburst = hburst;
   assign b0.hprot = hprot;
   assign b3.hprot = hprot;
   assign b0.htrans = htrans;
   assign b3.htrans = htrans;
   assign b0.hwdata = hwdata;
   assign b3.hwdata = hwdata;
   logic rdy, rsp, er;
   logic [31:0] rd;
   assign rdy = which ? b3.hready : b0.hready;
   assign rsp = which ? b3.hresp : b0.hresp;
   assign er = which ? b3.error : b0.error;
   assign rd = which ? b3.hrdata : b0.hrdata;
   int total = 0, passed = 0;
   logic exp_on = 1'b0, exp_dat_on = 1'b0;
   logic [2:0] exp_tup = '0;
   logic [31:0] exp_dat = '0, last_rd = '0;
   string exp_name = "";
   logic [7:0] mm [2][64];
   task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", n, got, exp);
   endtask
   // {hready, hresp, error} and, on read completions, hrdata
   always @(negedge clk)
      if (exp_on) begin
         check(exp_name, 32'({rdy, rsp, er}), 32'(exp_tup));
         if (exp_dat_on) begin
            check({exp_name, "_data"}, rd, exp_dat);
            last_rd = rd;
         end
      end
   function automatic logic is_err(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [3:0] p);
      return s > 3'd2 || a % (32'd1 << s) != 0 || a >= 4 * DEPTH || (PROT && w && !p[1] && a >= 2 * DEPTH);
   endfunction
   function automatic logic [31:0] mword(input logic wh, input logic [31:0] a);
      int b;
      b = int'(a) & ~3;
      return {mm[wh][b+3], mm[wh][b+2], mm[wh][b+1], mm[wh][b]};
   endfunction
   task automatic mwrite(input logic wh, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      for (int b = 0; b < (1 << s); b++) mm[wh][int'(a) + b] = d[8 * (int'(a % 4) + b) +: 8];
   endtask
   task automatic cyc(input logic [2:0] t, input logic dc, input logic [31:0] d);
      exp_on = 1'b1;
      exp_tup = t;
      exp_dat_on = dc;
      exp_dat = d;
      @(posedge clk);
      #1;
   endtask
   task automatic xfer(input string n, input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d, input logic [3:0] p);
      logic e;
      e = is_err(w, a, s, p);
      exp_name = n;
      hsel = 1'b1;
      htrans = 2'b10;
      hwrite = w;
      haddr = a;
      hsize = s;
      hprot = p;
      cyc(3'b100, 1'b0, 32'h0);
      hsel = 1'b0;
      htrans = 2'b00;
      hwdata = d;
      if (e) begin
         cyc(3'b010, 1'b0, 32'h0);
         cyc(3'b111, 1'b0, 32'h0);
      end else begin
         repeat (which ? 3 : 0) cyc(3'b000, 1'b0, 32'h0);
         cyc(3'b100, !w, w ? 32'h0 : mword(which, a));
         if (w) mwrite(which, a, s, d);
      end
      exp_on = 1'b0;
   endtask
   task automatic raw(input logic [31:0] a, input logic [31:0] d);
      exp_name = "raw";
      hsel = 1'b1;
      htrans = 2'b10;
      hwrite = 1'b1;
      haddr = a;
      hsize = 3'd2;
      hprot = 4'h3;
      cyc(3'b100, 1'b0, 32'h0);
      hwrite = 1'b0;
      hwdata = d;
      cyc(3'b100, 1'b0, 32'h0);
      mwrite(which, a, 3'd2, d);
      hsel = 1'b0;
      htrans = 2'b00;
      cyc(3'b100, 1'b1, mword(which, a));
      exp_on = 1'b0;
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_resp0", 32'({b0.hready, b0.hresp, b0.error}), 32'b100);
      check("rst_resp3", 32'({b3.hready, b3.hresp, b3.error}), 32'b100);
      check("rst_rdata0", b0.hrdata, 32'h0);
      check("rst_rdata3", b3.hrdata, 32'h0);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      which = 1'b0;
      xfer("w_dead", 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 4'h3);
      xfer("r_dead", 1'b0, 32'h10, 3'd2, 32'h0, 4'h3);
      check("lit_dead", last_rd, 32'hDEADBEEF);
      xfer("w_1122", 1'b1, 32'h10, 3'd2, 32'h11223344, 4'h3);
      xfer("w_byte13", 1'b1, 32'h13, 3'd0, 32'hAA5A5A5A, 4'h3);
      xfer("r_byte13", 1'b0, 32'h10, 3'd2, 32'h0, 4'h3);
      check("lit_byte13", last_rd, 32'hAA223344);
      xfer("w_5566", 1'b1, 32'h14, 3'd2, 32'h55667788, 4'h3);
      xfer("w_half16", 1'b1, 32'h16, 3'd1, 32'hABCD0000, 4'h3);
      xfer("w_byte15", 1'b1, 32'h15, 3'd0, 32'h0000EE00, 4'h3);
      xfer("r_lanes", 1'b0, 32'h14, 3'd2, 32'h0, 4'h3);
      check("lit_lanes", last_rd, 32'hABCDEE88);
      xfer("w_cafe", 1'b1, 32'h0, 3'd2, 32'hCAFEF00D, 4'h3);
      xfer("e_half01", 1'b1, 32'h1, 3'd1, 32'h12345678, 4'h3);
      xfer("e_range_w", 1'b1, 32'h40, 3'd2, 32'h87654321, 4'h3);
      xfer("e_range_r", 1'b0, 32'h40, 3'd2, 32'h0, 4'h3);
      xfer("e_size", 1'b0, 32'h18, 3'd3, 32'h0, 4'h3);
      xfer("r_cafe", 1'b0, 32'h0, 3'd2, 32'h0, 4'h3);
      check("lit_cafe", last_rd, 32'hCAFEF00D);
      xfer("w_1234", 1'b1, 32'h24, 3'd2, 32'h12345678, 4'h3);
      raw(32'h24, 32'h0BADF00D);
      check("lit_raw", last_rd, 32'h0BADF00D);
      exp_name = "busy";
      hsel = 1'b1;
      htrans = 2'b01;
      hwrite = 1'b1;
      haddr = 32'h10;
      hsize = 3'd2;
      hwdata = 32'h99999999;
      cyc(3'b100, 1'b0, 32'h0);
      exp_name = "nosel";
      hsel = 1'b0;
      htrans = 2'b10;
      cyc(3'b100, 1'b0, 32'h0);
      htrans = 2'b00;
      cyc(3'b100, 1'b0, 32'h0);
      exp_on = 1'b0;
      xfer("r_noeffect", 1'b0, 32'h10, 3'd2, 32'h0, 4'h3);
      xfer("w_top_priv", 1'b1, 32'h3C, 3'd2, 32'h0F0F0F0F, 4'h3);
      xfer("w_top_user", 1'b1, 32'h3C, 3'd2, 32'hF0F0F0F0, 4'h1);
      xfer("r_top", 1'b0, 32'h3C, 3'd2, 32'h0, 4'h3);
`ifdef AHB_SLV_PROT_EN
      check("lit_top", last_rd, 32'h0F0F0F0F);
      xfer("w_top_priv2", 1'b1, 32'h3C, 3'd2, 32'h5A5AA5A5, 4'h3);
      xfer("r_top2", 1'b0, 32'h3C, 3'd2, 32'h0, 4'h3);
      check("lit_top2", last_rd, 32'h5A5AA5A5);
`else
      check("lit_top", last_rd, 32'hF0F0F0F0);
`endif
      which = 1'b1;
      xfer("w3_1357", 1'b1, 32'h10, 3'd2, 32'h13579BDF, 4'h3);
      xfer("r3_1357", 1'b0, 32'h10, 3'd2, 32'h0, 4'h3);
      check("lit3_1357", last_rd, 32'h13579BDF);
      xfer("w3_byte", 1'b1, 32'h21, 3'd2, 32'h0, 4'h3);
      xfer("e3_range", 1'b0, 32'h40, 3'd2, 32'h0, 4'h3);
      xfer("r3_again", 1'b0, 32'h10, 3'd2, 32'h0, 4'h3);
      exp_name = "rst_wait";
      hsel = 1'b1;
      htrans = 2'b10;
      hwrite = 1'b1;
      haddr = 32'h10;
      hsize = 3'd2;
      cyc(3'b100, 1'b0, 32'h0);
      hsel = 1'b0;
      htrans = 2'b00;
      hwdata = 32'hFFFF0000;
      cyc(3'b000, 1'b0, 32'h0);
      exp_on = 1'b0;
      #2 rstn = 1'b0;
      #1;
      check("rst_mid_resp", 32'({b3.hready, b3.hresp, b3.error}), 32'b100);
      check("rst_mid_rdata", b3.hrdata, 32'h0);
      @(posedge clk);
      #1 rstn = 1'b1;
      xfer("r3_after_rst", 1'b0, 32'h10, 3'd2, 32'h0, 4'h3);
      check("lit3_after_rst", last_rd, 32'h13579BDF);
      which = 1'b0;
      xfer("r0_after_rst", 1'b0, 32'h0, 3'd2, 32'h0, 4'h3);
      check("lit0_after_rst", last_rd, 32'hCAFEF00D);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
